dmem_port_ctrl: RTL and testbench

- Sequences and shares the single-port-write data memory (DEPTH x 32, combinational read, posedge write, byte-addressed word index = addr>>2).
- After reset, copies the initial image into memory one word per cycle.
- Then arbitrates memory access between the pipeline MEM stage (port A, priority, single-cycle) and a debug/loader port (port B, valid/ready).
- Sits between the CPU core / debug bridge and the data memory plus its initial-image ROM.

---
 rtl/dmem_port_ctrl_if.sv | 44 ++++
 rtl/dmem_port_ctrl.sv | 149 ++++++++++++++
 tb/tb_dmem_port_ctrl.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_port_ctrl_if.sv
// Bundles the CPU port A, debug port B, init-image ROM and data-memory signals
// seen by dmem_port_ctrl; slave is the controller's view, master the environment's.
interface dmem_port_ctrl_if #(
    parameter int AW = 8
);
    logic          a_req;
    logic          a_we;
    logic [31:0]   a_addr;
    logic [31:0]   a_wdata;
    logic [31:0]   a_rdata;
    logic          a_stall;

    logic          b_valid;
    logic          b_we;
    logic [31:0]   b_addr;
    logic [31:0]   b_wdata;
    logic          b_ready;
    logic          b_rvalid;
    logic [31:0]   b_rdata;

    logic [AW-1:0] init_addr;
    logic [31:0]   init_data;
    logic          init_done;

    logic [31:0]   mem_raddr;
    logic [31:0]   mem_rdata;
    logic          mem_we;
    logic [31:0]   mem_waddr;
    logic [31:0]   mem_wdata;

    modport master (
        output a_req, a_we, a_addr, a_wdata, b_valid, b_we, b_addr, b_wdata,
               init_data, mem_rdata,
        input  a_rdata, a_stall, b_ready, b_rvalid, b_rdata, init_addr, init_done,
               mem_raddr, mem_we, mem_waddr, mem_wdata
    );

    modport slave (
        input  a_req, a_we, a_addr, a_wdata, b_valid, b_we, b_addr, b_wdata,
               init_data, mem_rdata,
        output a_rdata, a_stall, b_ready, b_rvalid, b_rdata, init_addr, init_done,
               mem_raddr, mem_we, mem_waddr, mem_wdata
    );
endinterface

// File: rtl/dmem_port_ctrl.sv
// Data-memory port controller: copies the init image after reset, then shares the
// single memory port between the MEM stage (port A, priority) and a debug port B.
module dmem_port_ctrl #(
    parameter int DEPTH    = 256,
    parameter int AW       = 8,
    parameter int MAX_WAIT = 4
) (
    input logic             clk,
    input logic             rst,
    dmem_port_ctrl_if.slave bus
);
    localparam int WW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {INIT, RUN, FORCE_B} stateT;

    stateT         state;
    stateT         stateNext;
    logic [AW-1:0] initCnt;
    logic [WW-1:0] waitCnt;
    logic [WW-1:0] waitNext;
    logic          initDone;
    logic          bRvalid;
    logic [31:0]   bRdata;
    logic          aOwn;
    logic          bOwn;
    logic          bReady;
    logic          bHs;
    logic [AW-1:0] aIdx;
    logic [AW-1:0] bIdx;
    logic          unusedAddrBits;

    assign aIdx = bus.a_addr[AW+1:2];
    assign bIdx = bus.b_addr[AW+1:2];
    assign unusedAddrBits = ^{bus.a_addr[31:AW+2], bus.a_addr[1:0],
                              bus.b_addr[31:AW+2], bus.b_addr[1:0]};
    assign bHs = bus.b_valid & bReady;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= INIT;
            waitCnt  <= '0;
            initCnt  <= '0;
            initDone <= 1'b0;
        end else begin
            state   <= stateNext;
            waitCnt <= waitNext;
            if (state == INIT) begin
                initCnt <= initCnt + 1'b1;
            end
            if (state == INIT && stateNext == RUN) begin
                initDone <= 1'b1;
            end
        end
    end

    // Port B is forced through after MAX_WAIT consecutive refused cycles.
    always_comb begin
        stateNext = state;
        waitNext  = waitCnt;
        case (state)
            INIT: begin
                waitNext = '0;
                if (initCnt == AW'(DEPTH - 1)) begin
                    stateNext = RUN;
                end
            end
            RUN: begin
                if (!bus.b_valid || bHs) begin
                    waitNext = '0;
                end else if (waitCnt == WW'(MAX_WAIT - 1)) begin
                    waitNext  = '0;
                    stateNext = FORCE_B;
                end else begin
                    waitNext = waitCnt + 1'b1;
                end
            end
            FORCE_B: begin
                waitNext  = '0;
                stateNext = RUN;
            end
            default: begin
                waitNext  = '0;
                stateNext = INIT;
            end
        endcase
    end

    always_comb begin
        aOwn          = 1'b0;
        bOwn          = 1'b0;
        bReady        = 1'b0;
        bus.a_stall   = 1'b1;
        bus.mem_we    = 1'b0;
        bus.mem_raddr = '0;
        bus.mem_waddr = '0;
        bus.mem_wdata = '0;
        case (state)
            INIT: begin
                bus.mem_we    = 1'b1;
                bus.mem_waddr = {{(30-AW){1'b0}}, initCnt, 2'b00};
                bus.mem_wdata = bus.init_data;
            end
            RUN: begin
                bus.a_stall = 1'b0;
                aOwn        = bus.a_req;
                bOwn        = !bus.a_req;
            end
            FORCE_B: begin
                bOwn = 1'b1;
            end
            default: begin
                bOwn = 1'b0;
            end
        endcase
        if (aOwn) begin
            bus.mem_raddr = {{(30-AW){1'b0}}, aIdx, 2'b00};
            bus.mem_waddr = {{(30-AW){1'b0}}, aIdx, 2'b00};
            bus.mem_we    = bus.a_we;
            bus.mem_wdata = bus.a_wdata;
        end
        if (bOwn) begin
            bReady        = 1'b1;
            bus.mem_raddr = {{(30-AW){1'b0}}, bIdx, 2'b00};
            bus.mem_waddr = {{(30-AW){1'b0}}, bIdx, 2'b00};
            bus.mem_we    = bus.b_valid & bus.b_we;
            bus.mem_wdata = bus.b_wdata;
        end
        bus.b_ready = bReady;
    end

    // Every accepted B request answers with a one-cycle b_rvalid; only reads load b_rdata.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bRvalid <= 1'b0;
            bRdata  <= '0;
        end else begin
            bRvalid <= bHs;
            if (bHs && !bus.b_we) begin
                bRdata <= bus.mem_rdata;
            end
        end
    end

    assign bus.a_rdata   = aOwn ? bus.mem_rdata : 32'h0;
    assign bus.b_rvalid  = bRvalid;
    assign bus.b_rdata   = bRdata;
    assign bus.init_addr = initCnt;
    assign bus.init_done = initDone;
endmodule

// File: tb/tb_dmem_port_ctrl.sv
// Self-checking bench for dmem_port_ctrl: behavioural memory/arbiter model compared
// every cycle, plus directed checks with hand-computed values.
module tb_dmem_port_ctrl;
    localparam int DEPTH    = 256;
    localparam int AW       = 8;
    localparam int MAX_WAIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    dmem_port_ctrl_if #(.AW(AW)) bus ();

    dmem_port_ctrl #(.DEPTH(DEPTH), .AW(AW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    logic [31:0] tbMem [DEPTH];

    always @(posedge clk) begin
        if (bus.mem_we) begin
            tbMem[bus.mem_waddr[AW+1:2]] <= bus.mem_wdata;
        end
    end
    assign bus.mem_rdata = tbMem[bus.mem_raddr[AW+1:2]];

    always_comb begin
        bus.init_data = 32'hA500_0000 + {24'h0, bus.init_addr};
    end

    function automatic logic [31:0] rom(input int k);
        return 32'hA500_0000 + 32'(k);
    endfunction

    function automatic logic [31:0] byteOf(input logic [31:0] addr);
        return {22'h0, addr[AW+1:2], 2'b00};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit aReq, input bit aWe, input logic [31:0] aAddr,
                                 input logic [31:0] aWdata, input bit bValid, input bit bWe,
                                 input logic [31:0] bAddr, input logic [31:0] bWdata);
        bus.a_req   = aReq;
        bus.a_we    = aWe;
        bus.a_addr  = aAddr;
        bus.a_wdata = aWdata;
        bus.b_valid = bValid;
        bus.b_we    = bWe;
        bus.b_addr  = bAddr;
        bus.b_wdata = bWdata;
    endtask

    // Model state: words copied since reset, shadow memory, pending B response, refusal streak.
    int          initCycles = 0;
    logic [31:0] refMem [DEPTH];
    bit          forceNow   = 0;
    int          refused    = 0;
    bit          respValid  = 0;
    logic [31:0] respData   = 0;
    bit          aOwner;
    bit          nextForce;
    logic [31:0] aWord;
    logic [31:0] bWord;

    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("rstStall", bus.a_stall, 1);
            checkOutput("rstReady", bus.b_ready, 0);
            checkOutput("rstMemWe", bus.mem_we, 1);
            checkOutput("rstWaddr", bus.mem_waddr, 0);
            checkOutput("rstInitAddr", bus.init_addr, 0);
            checkOutput("rstDone", bus.init_done, 0);
            checkOutput("rstRvalid", bus.b_rvalid, 0);
            checkOutput("rstRdata", bus.b_rdata, 0);
            checkOutput("rstArdata", bus.a_rdata, 0);
            initCycles = 0;
            forceNow   = 0;
            refused    = 0;
            respValid  = 0;
            respData   = 0;
            refMem[0]  = rom(0);
        end else if (initCycles < DEPTH) begin
            checkOutput("initStall", bus.a_stall, 1);
            checkOutput("initReady", bus.b_ready, 0);
            checkOutput("initMemWe", bus.mem_we, 1);
            checkOutput("initWaddr", bus.mem_waddr, 32'(initCycles * 4));
            checkOutput("initAddr", bus.init_addr, 32'(initCycles));
            checkOutput("initWdata", bus.mem_wdata, rom(initCycles));
            checkOutput("initDone", bus.init_done, 0);
            checkOutput("initRvalid", bus.b_rvalid, 0);
            checkOutput("initRdata", bus.b_rdata, respData);
            checkOutput("initArdata", bus.a_rdata, 0);
            refMem[initCycles] = rom(initCycles);
            initCycles++;
        end else begin
            aOwner = !forceNow && bus.a_req;
            aWord  = byteOf(bus.a_addr);
            bWord  = byteOf(bus.b_addr);
            checkOutput("runDone", bus.init_done, 1);
            checkOutput("runStall", bus.a_stall, forceNow);
            checkOutput("runReady", bus.b_ready, !aOwner);
            checkOutput("runRvalid", bus.b_rvalid, respValid);
            checkOutput("runRdata", bus.b_rdata, respData);
            if (aOwner) begin
                checkOutput("aMemWe", bus.mem_we, bus.a_we);
                checkOutput("aRaddr", bus.mem_raddr, aWord);
                checkOutput("aRdata", bus.a_rdata, refMem[aWord[AW+1:2]]);
                if (bus.a_we) begin
                    checkOutput("aWaddr", bus.mem_waddr, aWord);
                    checkOutput("aWdata", bus.mem_wdata, bus.a_wdata);
                end
            end else begin
                checkOutput("bMemWe", bus.mem_we, bus.b_valid & bus.b_we);
                if (forceNow) checkOutput("stallArdata", bus.a_rdata, 0);
                if (bus.b_valid && !bus.b_we) checkOutput("bRaddr", bus.mem_raddr, bWord);
                if (bus.b_valid && bus.b_we) begin
                    checkOutput("bWaddr", bus.mem_waddr, bWord);
                    checkOutput("bWdata", bus.mem_wdata, bus.b_wdata);
                end
            end
            respValid = 0;
            nextForce = 0;
            if (aOwner && bus.a_we) refMem[aWord[AW+1:2]] = bus.a_wdata;
            if (!aOwner && bus.b_valid) begin
                if (bus.b_we) refMem[bWord[AW+1:2]] = bus.b_wdata;
                else respData = refMem[bWord[AW+1:2]];
                respValid = 1;
                refused   = 0;
            end else if (bus.b_valid) begin
                refused++;
                if (refused == MAX_WAIT) begin
                    nextForce = 1;
                    refused   = 0;
                end
            end else begin
                refused = 0;
            end
            forceNow = nextForce;
        end
    end

    // Starting just after reset release: the copy must take exactly DEPTH posedges.
    task automatic waitInit();
        @(negedge clk);
        checkOutput("firstWaddr", bus.mem_waddr, 32'h000);
        @(negedge clk);
        checkOutput("secondWaddr", bus.mem_waddr, 32'h004);
        repeat (DEPTH - 2) @(posedge clk);
        #1;
        checkOutput("doneBefore", bus.init_done, 0);
        @(posedge clk);
        #1;
        checkOutput("doneAt256", bus.init_done, 1);
    endtask

    function automatic logic [31:0] randAddr();
        logic [31:0] a;
        a = $urandom();
        if ($urandom_range(3) != 0) a = a & 32'h0000_007F;
        return a;
    endfunction

    bit acc;
    int aProb;
    int memBad;

    initial begin
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        waitInit();
        checkOutput("img0", tbMem[0], 32'hA500_0000);
        checkOutput("img100", tbMem[100], 32'hA500_0064);
        checkOutput("img255", tbMem[255], 32'hA500_00FF);

        applyStimulus(1, 1, 32'h10, 32'hDEAD_BEEF, 0, 0, 0, 0);
        @(posedge clk); #1;
        applyStimulus(1, 0, 32'h10, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("aReadBack", bus.a_rdata, 32'hDEAD_BEEF);
        checkOutput("aNoStall", bus.a_stall, 0);

        @(posedge clk); #1;
        applyStimulus(1, 1, 32'h20, 32'h1234_5678, 0, 0, 0, 0);
        @(posedge clk); #1;
        applyStimulus(0, 0, 0, 0, 1, 0, 32'h20, 0);
        @(negedge clk);
        checkOutput("bReadyNow", bus.b_ready, 1);
        @(posedge clk); #1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("bRvalidPulse", bus.b_rvalid, 1);
        checkOutput("bRdataVal", bus.b_rdata, 32'h1234_5678);
        @(negedge clk);
        checkOutput("bRvalidDrop", bus.b_rvalid, 0);

        @(posedge clk); #1;
        applyStimulus(1, 0, 32'h10, 0, 1, 0, 32'h20, 0);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i <= 4) checkOutput($sformatf("starveRefuse%0d", i), bus.b_ready, 0);
            if (i == 5) begin
                checkOutput("forceReady", bus.b_ready, 1);
                checkOutput("forceStall", bus.a_stall, 1);
            end
            if (i == 6) begin
                checkOutput("resumeStall", bus.a_stall, 0);
                checkOutput("resumeArdata", bus.a_rdata, 32'hDEAD_BEEF);
                checkOutput("forceRvalid", bus.b_rvalid, 1);
                checkOutput("forceRdata", bus.b_rdata, 32'h1234_5678);
            end
            @(posedge clk); #1;
            if (i == 5) bus.b_valid = 0;
        end

        applyStimulus(1, 1, 32'h403, 32'h5555_AAAA, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("wrapWaddr", bus.mem_waddr, 32'h000);
        checkOutput("wrapWe", bus.mem_we, 1);
        @(posedge clk); #1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("wrapWord0", tbMem[0], 32'h5555_AAAA);

        applyStimulus(0, 0, 0, 0, 1, 0, 32'h10, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("dropRvalid", bus.b_rvalid, 0);
        checkOutput("dropDone", bus.init_done, 0);
        @(posedge clk); #1 rst = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        checkOutput("midInitAddr", bus.init_addr, 32'd100);
        rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        waitInit();
        checkOutput("reimgWord0", tbMem[0], 32'hA500_0000);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            acc = bus.b_valid && bus.b_ready;
            @(posedge clk); #1;
            case ((c / 500) % 3)
                0:       aProb = 20;
                1:       aProb = 60;
                default: aProb = 95;
            endcase
            bus.a_req   = ($urandom_range(99) < aProb);
            bus.a_we    = 1'($urandom_range(1));
            bus.a_addr  = randAddr();
            bus.a_wdata = $urandom();
            if (!bus.b_valid || acc) begin
                bus.b_valid = ($urandom_range(99) < 60);
                bus.b_we    = 1'($urandom_range(1));
                bus.b_addr  = randAddr();
                bus.b_wdata = $urandom();
            end
        end
        @(negedge clk);
        acc = bus.b_valid && bus.b_ready;
        @(posedge clk); #1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;

        memBad = 0;
        for (int k = 0; k < DEPTH; k++) begin
            if (tbMem[k] !== refMem[k]) memBad++;
        end
        checkOutput("memImage", 32'(memBad), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
